maxpool_unit: RTL
=================

Name: maxpool_unit

Overview:
- 2x2, stride-2 max-pooling stage fed directly by the ReLU activation output stream (16-bit signed data plus a valid strobe, no backpressure).
- Consumes one feature map in row-major order and emits one pooled value per 2x2 window.
- A single line buffer holds horizontal pair maxima from even rows.
- Output uses the same data/valid stream format, so it can feed another stage or the output buffer.

Parameters:
- IMG_W, 28, input feature-map width in pixels; must be even and >= 2 (elaboration-time assertion).
- IMG_H, 28, input feature-map height in pixels; must be even and >= 2 (elaboration-time assertion).
- DATA_W, 16, sample width; two's complement signed.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  signed input sample, row-major
- valid_in  input  1  in_data valid this cycle
- frame_clear  input  1  synchronous restart of frame position counters
- out_data  output  DATA_W  signed pooled value
- valid_out  output  1  out_data valid, single-cycle pulse per window
- frame_done  output  1  single-cycle pulse coincident with the last pooled output of a frame

Behaviour:
- Reset (rst_n=0, async):
  - out_data=0, valid_out=0, frame_done=0.
  - col=0, row=0, pair_reg=0.
  - Line buffer contents are not reset. Every entry is written on an even row before it is read on the following odd row.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1.
  - They advance only on cycles with valid_in=1.
  - At col=IMG_W-1: col wraps to 0 and row increments.
  - At col=IMG_W-1, row=IMG_H-1: both wrap to 0, so the next frame starts with no idle cycle required.
- Gaps: valid_in=0 holds all state. valid_out and frame_done are deasserted the next cycle. out_data holds its last value.
- Per accepted sample:
  - col even: pair_reg <= in_data.
  - col odd: hmax = signed max(pair_reg, in_data).
    - row even: linebuf[col>>1] <= hmax.
    - row odd: out_data <= signed max(linebuf[col>>1], hmax) and valid_out <= 1.
- Ties: either operand may be selected; the value is identical.
- Latency: valid_out asserts 1 cycle after the sample at (odd row, odd col) is accepted.
  - Output rate is IMG_W/2 values per odd row.
  - (IMG_W/2)*(IMG_H/2) values per frame.
- frame_done: asserted in the same cycle as valid_out for the window at (IMG_H-1, IMG_W-1). Deasserted otherwise.
- Arithmetic: compares are full-width signed. There is no saturation or width growth. Negative inputs are legal and pooled correctly even though the upstream ReLU never produces them.
- frame_clear=1:
  - Next state is col=0, row=0. No valid_out or frame_done is generated from the cleared partial frame.
  - If valid_in=1 in the same cycle, that sample is processed as pixel (0,0) and counters advance to col=1.
- Reset mid-frame: partial frame is discarded. The first valid_in after rst_n deasserts is pixel (0,0).
- Line buffer: IMG_W/2 entries of DATA_W. One write or one read per accepted odd-column sample, never both to the same entry in one cycle.

Test Plan:
- IMG_W=4, IMG_H=4. Stream 0..15 row-major, valid_in continuous -> outputs 5, 7, 13, 15 in order, each 1 cycle after inputs 5, 7, 13, 15. frame_done with the 15.
- Same stream with valid_in toggled 1/0 every cycle plus random 0-3 cycle gaps -> identical output sequence 5, 7, 13, 15. valid_out is a single-cycle pulse each time.
- IMG_W=4, IMG_H=4. Inputs -1, -8, -3, -2, then -5, -4, -7, -6, etc. -> first output -1, second -2. Verifies signed compare.
- Two frames back-to-back, second frame values 100..115 -> outputs 5, 7, 13, 15, 105, 107, 113, 115. Exactly two frame_done pulses.
- Assert rst_n low after 6 samples of a frame, then send 0..15 -> only 5, 7, 13, 15 emitted. All outputs 0 during reset.
- Assert frame_clear together with valid_in on the 7th sample (value 200), then continue 201..215 -> this frame's outputs are computed with 200 as pixel (0,0), e.g. first output 205. No output from the aborted partial frame.

Source files
------------

// File: rtl/maxpool_unit.sv
// 2x2 stride-2 signed max-pooling over a row-major valid-strobed stream.
// Even rows park horizontal pair maxima in a line buffer; odd rows combine and emit.
module maxpool_unit #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     valid_in,
    input  logic                     frame_clear,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB  = IMG_W / 2;
    localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

    generate
        if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
            $error("maxpool_unit: IMG_W must be even and >= 2");
        end
        if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
            $error("maxpool_unit: IMG_H must be even and >= 2");
        end
    endgenerate

    logic [CW-1:0]            col_q, col_d, cur_col;
    logic [RW-1:0]            row_q, row_d, cur_row;
    logic signed [DATA_W-1:0] pair_q, pair_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     vout_q, vout_d;
    logic                     fdone_q, fdone_d;
    logic signed [DATA_W-1:0] hmax, lb_rdata, pool;
    logic [LBW-1:0]           lb_idx;
    logic                     lb_we;
    logic                     col_last, row_last;

    // Contents are written on every even row before the odd row reads them.
    logic signed [DATA_W-1:0] linebuf [LB];

    // frame_clear rebases the position so a same-cycle sample is pixel (0,0).
    assign cur_col  = frame_clear ? '0 : col_q;
    assign cur_row  = frame_clear ? '0 : row_q;
    assign col_last = (cur_col == CW'(IMG_W - 1));
    assign row_last = (cur_row == RW'(IMG_H - 1));
    assign lb_idx   = LBW'(cur_col >> 1);
    assign lb_rdata = linebuf[lb_idx];
    assign hmax     = (in_data > pair_q) ? in_data : pair_q;
    assign pool     = (lb_rdata > hmax) ? lb_rdata : hmax;

    always_comb begin
        col_d   = cur_col;
        row_d   = cur_row;
        pair_d  = pair_q;
        out_d   = out_q;
        vout_d  = 1'b0;
        fdone_d = 1'b0;
        lb_we   = 1'b0;
        if (valid_in) begin
            if (!cur_col[0]) begin
                pair_d = in_data;
            end else if (!cur_row[0]) begin
                lb_we = 1'b1;
            end else begin
                out_d   = pool;
                vout_d  = 1'b1;
                fdone_d = col_last && row_last;
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            out_q   <= '0;
            vout_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            out_q   <= out_d;
            vout_q  <= vout_d;
            fdone_q <= fdone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= hmax;
        end
    end

    assign out_data   = out_q;
    assign valid_out  = vout_q;
    assign frame_done = fdone_q;

endmodule
